// File: rtl/block_xfer_ctrl.sv
// LDM/STM-style block transfer sequencer: walks a 16-bit register list in
// ascending order, issuing one word access per selected register.
module block_xfer_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        str_addr,
    input  logic [31:0]       str_data,
    output logic              w_en_ldr,
    output logic [3:0]        w_addr_ldr,
    output logic [31:0]       w_data_ldr,
    output logic              w_en1,
    output logic [3:0]        w_addr1,
    output logic [31:0]       w_data1,
    output logic              busy,
    output logic              done,
    output logic              pc_loaded
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       mask;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] final_base;
    logic              is_load_q;
    logic              wback_q;
    logic [3:0]        base_reg_q;

    logic [4:0]        n_cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [3:0]        cur_reg;
    logic [15:0]       mask_rest;

    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            n_cnt = n_cnt + 5'(reg_list[i]);
        end
    end

    // Addresses always ascend, so decrementing modes start 4n below the base.
    always_comb begin
        span = ADDR_W'({n_cnt, 2'b00});
        case ({up, pre})
            2'b10:   start_addr = base_addr;
            2'b11:   start_addr = base_addr + ADDR_W'(4);
            2'b00:   start_addr = base_addr - span + ADDR_W'(4);
            default: start_addr = base_addr - span;
        endcase
    end

    always_comb begin
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                cur_reg = 4'(i);
            end
        end
    end

    assign mask_rest = mask & (mask - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mask       <= '0;
            list_q     <= '0;
            addr       <= '0;
            final_base <= '0;
            is_load_q  <= 1'b0;
            wback_q    <= 1'b0;
            base_reg_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask       <= reg_list;
                        list_q     <= reg_list;
                        addr       <= start_addr;
                        final_base <= up ? base_addr + span : base_addr - span;
                        is_load_q  <= is_load;
                        wback_q    <= wback;
                        base_reg_q <= base_reg;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        mask <= mask_rest;
                        addr <= addr + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so that every port reads zero in IDLE and reset.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        str_addr   = '0;
        w_en_ldr   = 1'b0;
        w_addr_ldr = '0;
        w_data_ldr = '0;
        w_en1      = 1'b0;
        w_addr1    = '0;
        w_data1    = '0;
        done       = 1'b0;
        pc_loaded  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (reg_list == 16'd0) ? FINISH : XFER;
                end
            end
            XFER: begin
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = addr;
                str_addr  = cur_reg;
                mem_wdata = str_data;
                if (mem_ready) begin
                    if (is_load_q) begin
                        w_en_ldr   = 1'b1;
                        w_addr_ldr = cur_reg;
                        w_data_ldr = mem_rdata;
                    end
                    if (mask_rest == 16'd0) begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                done      = 1'b1;
                pc_loaded = is_load_q && list_q[15];
                if (wback_q && (list_q != 16'd0) && !(is_load_q && list_q[base_reg_q])) begin
                    w_en1   = 1'b1;
                    w_addr1 = base_reg_q;
                    w_data1 = 32'(final_base);
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_ctrl.sv
// Scoreboard bench for block_xfer_ctrl: directed commands push expected
// accesses and completions; a negedge monitor pops and compares them.
module tb_block_xfer_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  rnum;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic        wen1;
        logic [3:0]  waddr1;
        logic [31:0] wdata1;
        logic        pc;
        int          lat;
    } fin_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  base_reg = '0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        wback = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata;
    logic [3:0]  str_addr;
    logic [31:0] str_data;
    logic        w_en_ldr;
    logic [3:0]  w_addr_ldr;
    logic [31:0] w_data_ldr;
    logic        w_en1;
    logic [3:0]  w_addr1;
    logic [31:0] w_data1;
    logic        busy;
    logic        done;
    logic        pc_loaded;

    acc_t acc_q[$];
    fin_t fin_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   stall_left = 0;

    block_xfer_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load),
        .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg),
        .up(up), .pre(pre), .wback(wback),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .str_addr(str_addr), .str_data(str_data),
        .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
        .w_en1(w_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .busy(busy), .done(done), .pc_loaded(pc_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Memory and regfile models produce recognisable patterns per address/register.
    assign mem_rdata = {16'hDA7A, mem_addr[15:0]};
    assign str_data  = {28'h5700000, str_addr};

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && stall_left > 0) begin
                mem_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pushAcc(input logic [31:0] a, input logic w, input logic [3:0] r, input logic [31:0] d);
        acc_t e;
        e.addr = a; e.we = w; e.rnum = r; e.data = d;
        acc_q.push_back(e);
    endtask

    task automatic pushFin(input logic e1, input logic [3:0] a1, input logic [31:0] d1, input logic pc, input int lat);
        fin_t f;
        f.wen1 = e1; f.waddr1 = a1; f.wdata1 = d1; f.pc = pc; f.lat = lat;
        fin_q.push_back(f);
    endtask

    task automatic setCmd(input logic ld, input logic [15:0] list, input logic [31:0] b,
                          input logic [3:0] br, input logic u, input logic p, input logic wb);
        is_load = ld; reg_list = list; base_addr = b; base_reg = br;
        up = u; pre = p; wback = wb;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("acc_leftover", acc_q.size(), 32'd0);
        checkOutput("fin_leftover", fin_q.size(), 32'd0);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] list, input logic [31:0] b,
                                 input logic [3:0] br, input logic u, input logic p, input logic wb);
        @(posedge clk);
        #1;
        setCmd(ld, list, b, br, u, p, wb);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_str_addr"}, {28'd0, str_addr}, 32'd0);
        checkOutput({tag, "_w_en_ldr"}, {31'd0, w_en_ldr}, 32'd0);
        checkOutput({tag, "_w_data_ldr"}, w_data_ldr, 32'd0);
        checkOutput({tag, "_w_en1"}, {31'd0, w_en1}, 32'd0);
        checkOutput({tag, "_w_data1"}, w_data1, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_pc_loaded"}, {31'd0, pc_loaded}, 32'd0);
    endtask

    // Monitor: compares every presented access and completion against the queues.
    always @(negedge clk) begin
        acc_t a;
        fin_t f;
        if (!rst) begin
            if (start && !busy) start_cyc = cyc;
            if (mem_req) begin
                if (acc_q.size() == 0) begin
                    checkOutput("unexpected_access", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    a = acc_q[0];
                    checkOutput("mem_addr", mem_addr, a.addr);
                    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, a.we});
                    checkOutput("str_addr", {28'd0, str_addr}, {28'd0, a.rnum});
                    if (a.we) checkOutput("mem_wdata", mem_wdata, a.data);
                    if (mem_ready) begin
                        checkOutput("w_en_ldr", {31'd0, w_en_ldr}, {31'd0, !a.we});
                        if (!a.we) begin
                            checkOutput("w_addr_ldr", {28'd0, w_addr_ldr}, {28'd0, a.rnum});
                            checkOutput("w_data_ldr", w_data_ldr, a.data);
                        end
                        void'(acc_q.pop_front());
                    end else begin
                        checkOutput("w_en_ldr_stall", {31'd0, w_en_ldr}, 32'd0);
                    end
                end
            end else begin
                checkOutput("w_en_ldr_noreq", {31'd0, w_en_ldr}, 32'd0);
            end
            if (done) begin
                if (fin_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    f = fin_q.pop_front();
                    checkOutput("done_latency", cyc - start_cyc, f.lat);
                    checkOutput("w_en1", {31'd0, w_en1}, {31'd0, f.wen1});
                    checkOutput("pc_loaded", {31'd0, pc_loaded}, {31'd0, f.pc});
                    checkOutput("busy_at_done", {31'd0, busy}, 32'd1);
                    if (f.wen1) begin
                        checkOutput("w_addr1", {28'd0, w_addr1}, {28'd0, f.waddr1});
                        checkOutput("w_data1", w_data1, f.wdata1);
                    end
                end
            end else begin
                checkOutput("w_en1_not_done", {31'd0, w_en1}, 32'd0);
                checkOutput("pc_loaded_not_done", {31'd0, pc_loaded}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] IA load 0x000F base 0x100 wback R4");
        pushAcc(32'h100, 1'b0, 4'd0, 32'hDA7A0100);
        pushAcc(32'h104, 1'b0, 4'd1, 32'hDA7A0104);
        pushAcc(32'h108, 1'b0, 4'd2, 32'hDA7A0108);
        pushAcc(32'h10C, 1'b0, 4'd3, 32'hDA7A010C);
        pushFin(1'b1, 4'd4, 32'h110, 1'b0, 5);
        applyStimulus(1'b1, 16'h000F, 32'h100, 4'd4, 1'b1, 1'b0, 1'b1);

        $display("[TB] DB store 0x8003 base 0x200 wback R13");
        pushAcc(32'h1F4, 1'b1, 4'd0, 32'h57000000);
        pushAcc(32'h1F8, 1'b1, 4'd1, 32'h57000001);
        pushAcc(32'h1FC, 1'b1, 4'd15, 32'h5700000F);
        pushFin(1'b1, 4'd13, 32'h1F4, 1'b0, 4);
        applyStimulus(1'b0, 16'h8003, 32'h200, 4'd13, 1'b0, 1'b1, 1'b1);

        $display("[TB] IB load 0x0006 with base R1 in list");
        pushAcc(32'h304, 1'b0, 4'd1, 32'hDA7A0304);
        pushAcc(32'h308, 1'b0, 4'd2, 32'hDA7A0308);
        pushFin(1'b0, 4'd0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 16'h0006, 32'h300, 4'd1, 1'b1, 1'b1, 1'b1);

        $display("[TB] DA load 0x8010 with PC, wback R2");
        pushAcc(32'h5FC, 1'b0, 4'd4, 32'hDA7A05FC);
        pushAcc(32'h600, 1'b0, 4'd15, 32'hDA7A0600);
        pushFin(1'b1, 4'd2, 32'h5F8, 1'b1, 3);
        applyStimulus(1'b1, 16'h8010, 32'h600, 4'd2, 1'b0, 1'b0, 1'b1);

        $display("[TB] stalled IA load 0x0001");
        stall_left = 3;
        pushAcc(32'h400, 1'b0, 4'd0, 32'hDA7A0400);
        pushFin(1'b0, 4'd0, 32'h0, 1'b0, 5);
        applyStimulus(1'b1, 16'h0001, 32'h400, 4'd0, 1'b1, 1'b0, 1'b0);

        $display("[TB] empty list, second start while busy");
        pushFin(1'b0, 4'd0, 32'h0, 1'b0, 1);
        @(posedge clk);
        #1;
        setCmd(1'b1, 16'h0000, 32'h500, 4'd3, 1'b1, 1'b0, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("empty_busy", {31'd0, busy}, 32'd1);
        setCmd(1'b1, 16'h00FF, 32'h900, 4'd3, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ignored_start_busy", {31'd0, busy}, 32'd0);
        waitIdle();

        $display("[TB] reset during second access");
        pushAcc(32'h700, 1'b0, 4'd4, 32'hDA7A0700);
        @(posedge clk);
        #1;
        setCmd(1'b1, 16'h00F0, 32'h700, 4'd0, 1'b1, 1'b0, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("second_access_addr", mem_addr, 32'h704);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_reset_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_acc_leftover", acc_q.size(), 32'd0);

        $display("[TB] IA load 0x0030 after reset");
        pushAcc(32'h800, 1'b0, 4'd4, 32'hDA7A0800);
        pushAcc(32'h804, 1'b0, 4'd5, 32'hDA7A0804);
        pushFin(1'b1, 4'd0, 32'h808, 1'b0, 3);
        applyStimulus(1'b1, 16'h0030, 32'h800, 4'd0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_xfer_ctrl.md
# block_xfer_ctrl

Multi-register transfer sequencer for the register file. It takes one LDM/STM-style command, then walks the 16-bit register list in ascending order, issuing one word access per selected register. Loads are written back through the regfile's load write port, and stores read data through the store read port. When the command ends, an optional base-register update goes out on write port 1. The block sits between the decode/control FSM and the regfile plus data memory, and stalls on the memory handshake.

## Interface
- `ADDR_W`, default 32: memory byte-address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `is_load`  in  1  1 = load (memory to regs), 0 = store.
- `reg_list`  in  16  bit i set selects Ri.
- `base_addr`  in  ADDR_W  base register value (A_data).
- `base_reg`  in  4  base register index.
- `up`  in  1  1 = increment, 0 = decrement.
- `pre`  in  1  1 = adjust before the access (IB/DB), 0 = after (IA/DA).
- `wback`  in  1  write the final address to `base_reg`.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  write enable, qualified by `mem_req`.
- `mem_addr`  out  ADDR_W  word-aligned byte address.
- `mem_wdata`  out  32  store data, equal to `str_data`.
- `mem_ready`  in  1  access accepted this cycle; load data valid this cycle.
- `mem_rdata`  in  32  load data.
- `str_addr`  out  4  regfile store read address.
- `str_data`  in  32  regfile store read data.
- `w_en_ldr`, `w_addr_ldr`, `w_data_ldr`  out  1/4/32  regfile load write port.
- `w_en1`, `w_addr1`, `w_data1`  out  1/4/32  regfile port 1, used for base writeback.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `pc_loaded`  out  1  pulses with `done` when R15 was loaded.

## Operation
- **States:** IDLE, XFER, FINISH.
- **IDLE:**
  - `start` latches every command input and computes n = popcount(`reg_list`).
  - n = 0: go to FINISH.
  - n > 0: go to XFER.
  - `start` in any other state is ignored.
- **Start address,** with B = `base_addr`:
  - IA: B.
  - IB: B+4.
  - DA: B-4n+4.
  - DB: B-4n.
- Addresses always ascend by 4 while registers ascend by index. All arithmetic is modulo 2^ADDR_W, with no wrap detection.
- **XFER:**
  - The current register is the lowest set bit remaining in the pending mask.
  - Drive `mem_req`=1, `mem_we`=!`is_load`, `mem_addr`=current address, and `str_addr`=current register.
  - Hold all of these unchanged until `mem_ready`=1.
- **On `mem_ready`:**
  - Load: drive `w_en_ldr`=1, `w_addr_ldr`=current register and `w_data_ldr`=`mem_rdata`, combinationally in the same cycle.
  - Then clear the register's mask bit and add 4 to the address.
  - When the mask becomes empty, go to FINISH.
- **Final base:** up ? B+4n : B-4n.
- **FINISH:**
  - Pulse `done`.
  - `w_en1`=1 with `w_addr1`=`base_reg` and `w_data1`=final base when `wback`=1, n>0, and not (`is_load` and bit `base_reg` is set). In that excluded case the loaded value wins.
  - Pulse `pc_loaded` when `is_load` and bit 15 is set.
  - Return to IDLE.
- Store of `base_reg` stores the original, unmodified value, because writeback occurs only in FINISH.
- **Reset, at any time including mid-command:** state IDLE, mask cleared. `mem_req`, `mem_we`, `w_en_ldr`, `w_en1`, `busy`, `done` and `pc_loaded` are all 0; address and data outputs are 0. A partially completed command is abandoned, not resumed.

## Timing
- `start` is accepted at cycle 0.
- `busy` is 1 from cycle 1 through the FINISH cycle inclusive, and 0 in IDLE.
- With `mem_ready` tied high, access k (k = 0..n-1) occurs in cycle 1+k, and FINISH/`done` is in cycle n+1. Total latency is n+1 cycles.
- Each cycle `mem_ready` is low adds exactly one cycle. At most one access completes per cycle.
- n = 0: `done` is in cycle 1, with no memory access and no writeback.
- A new `start` can be accepted in the cycle after `done`.
- `mem_req` falls in the cycle after the last `mem_ready`.

## Test plan
- IA load, list 0x000F, B=0x100, `wback`=1, `base_reg`=4, ready=1:
  - Loads R0..R3 from 0x100, 0x104, 0x108, 0x10C in cycles 1-4.
  - `done` and `w_en1` (R4 = 0x110) in cycle 5.
- DB store, list 0x8003, B=0x200, ready=1:
  - Addresses 0x1F4 (R0), 0x1F8 (R1), 0x1FC (R15).
  - `str_addr` tracks these registers.
  - With `wback`=1: R13 = 0x1F4.
- Load with `base_reg`=1, list 0x0006, `wback`=1:
  - R1 and R2 are written.
  - `w_en1` stays 0 throughout.
  - `pc_loaded`=0.
- Stall: IA load, list 0x0001, `mem_ready` low for 3 cycles:
  - `mem_req`/`mem_addr` held for 4 cycles.
  - `w_en_ldr` only in the ready cycle.
  - `done` one cycle later.
- Empty list:
  - `done` in cycle 1.
  - No `mem_req` and no `w_en1`.
  - A second `start` while `busy` is ignored.
- Assert `rst` during the 2nd access of a 4-register load:
  - All outputs 0 immediately.
  - Idle after release.
  - The next command runs correctly from its first register.
